// File: rtl/act_check_pkg.sv
// Shared definitions for the activation response checker: golden-function
// mode codes, the run-control state encoding and the bit-exact golden model.
package act_check_pkg;

    localparam int ACT_RELU     = 0;
    localparam int ACT_LEAKY    = 1;
    localparam int ACT_HARDTANH = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } act_state_e;

    // Golden activation on a sign-extended input. The caller truncates the
    // result to its data width, which is where the activation block's own
    // WIDTH-bit result comes from.
    function automatic int act_golden(input int x, input int mode,
                                      input int shift, input int dp);
        int one;
        int y;
        one = 1 << dp;
        y   = x;
        case (mode)
            ACT_RELU:     y = (x < 0) ? 0 : x;
            ACT_LEAKY:    y = (x < 0) ? (x >>> shift) : x;
            ACT_HARDTANH: begin
                if (x > one)       y = one;
                else if (x < -one) y = -one;
                else               y = x;
            end
            default:      y = x;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/act_exp_fifo.sv
// Expected-value queue for the response checker. Synchronous FIFO with a
// same-cycle pop-frees-slot rule: a push into a full queue succeeds when a
// pop happens in the same cycle. No read-to-write bypass when empty.
module act_exp_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] pop_data_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int             AW         = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_COUNT = (AW+1)'(DEPTH);

    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [AW:0]       count_q;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              push_ok;
    logic              pop_ok;

    assign full_o     = (count_q == FULL_COUNT);
    assign empty_o    = (count_q == '0);
    assign pop_ok     = pop_i && !empty_o;
    assign push_ok    = push_i && (!full_o || pop_ok);
    assign pop_data_o = mem_q[rd_ptr_q];

    // Pointer and occupancy bookkeeping; clr_i empties the queue.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage write port.
    // NOTE: the storage array has no reset; occupancy is tracked by count_q,
    // so stale contents are never read and a reset would only cost flops.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/act_response_checker.sv
// Response-side checker for relu / leaky relu / hardtanh activation blocks.
// Queues a golden value per stimulus and compares it against each rdy-
// qualified DUT output, counting mismatches, underflows and comparisons.
// Optional feature macro: ACT_CHECK_FIRST_ERR_EN (first-mismatch capture).
module act_response_checker
    import act_check_pkg::*;
#(
    parameter int WIDTH                = 8,
    parameter int MODE                 = ACT_RELU,
    parameter int NEGATIVE_SLOPE_SHIFT = 5,
    parameter int DECIMAL_POINT        = 4,
    parameter int FIFO_DEPTH           = 4,
    parameter int SWEEP_LEN            = 256
) (
    input  logic                    iClk,
    input  logic                    iRst,
    input  logic                    start,
    input  logic                    stimValid,
    input  logic signed [WIDTH-1:0] stimData,
    input  logic signed [WIDTH-1:0] dutOut,
    input  logic                    dutRdy,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [15:0]             errCount,
    output logic [15:0]             cmpCount,
    output logic                    underflow,
    output logic                    overflow,
    output logic [WIDTH-1:0]        firstErrIn,
    output logic [WIDTH-1:0]        firstErrExp,
    output logic [WIDTH-1:0]        firstErrAct
);

    localparam logic [15:0] LAST_CMP = 16'(SWEEP_LEN - 1);

    // The stimulus input rides along with its expected value only when the
    // capture registers exist to consume it.
`ifdef ACT_CHECK_FIRST_ERR_EN
    localparam int FIFO_W = 2 * WIDTH;
`else
    localparam int FIFO_W = WIDTH;
`endif

    act_state_e        state_q, state_d;
    logic [15:0]       err_count_q, cmp_count_q;
    logic              underflow_q, overflow_q;
    logic [WIDTH-1:0]  exp_val;
    logic [WIDTH-1:0]  head_exp;
    logic [FIFO_W-1:0] fifo_wr_data, fifo_rd_data;
    logic              fifo_full, fifo_empty;
    logic              run_active, pop_evt, push_req, last_cmp;
    logic              uf_evt, of_evt, mismatch, err_inc;

    // Golden value for the stimulus presented this cycle.
    always_comb begin
        exp_val = WIDTH'(act_golden(int'(stimData), MODE,
                                    NEGATIVE_SLOPE_SHIFT, DECIMAL_POINT));
    end

    // A start pulse restarts the run, so traffic on that cycle is ignored.
    assign run_active = (state_q == ST_RUN) && !start;
    assign pop_evt    = run_active && dutRdy;
    assign last_cmp   = pop_evt && (cmp_count_q == LAST_CMP);
    assign push_req   = run_active && stimValid && !last_cmp;
    assign head_exp   = fifo_rd_data[WIDTH-1:0];
    assign uf_evt     = pop_evt && fifo_empty;
    assign mismatch   = pop_evt && !fifo_empty && (head_exp != dutOut);
    assign of_evt     = push_req && fifo_full && !pop_evt;
    assign err_inc    = mismatch || uf_evt;

    act_exp_fifo #(
        .DATA_W (FIFO_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (iClk),
        .rst_i       (iRst),
        .clr_i       (start),
        .push_i      (push_req),
        .push_data_i (fifo_wr_data),
        .pop_i       (pop_evt),
        .pop_data_o  (fifo_rd_data),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // Run-control state register.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic: start always (re)enters RUN; the last comparison ends it.
    // NOTE: state_d gets a default before the case so no path leaves it
    // unassigned, which would infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN: begin
                if (start)         state_d = ST_RUN;
                else if (last_cmp) state_d = ST_DONE;
            end
            ST_DONE: if (start) state_d = ST_RUN;
            default: state_d = ST_IDLE;
        endcase
    end

    // Comparison / error counters and sticky queue-fault flags.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            err_count_q <= '0;
            cmp_count_q <= '0;
            underflow_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else if (start) begin
            err_count_q <= '0;
            cmp_count_q <= '0;
            underflow_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            if (pop_evt) cmp_count_q <= cmp_count_q + 16'd1;
            if (err_inc && (err_count_q != 16'hFFFF))
                err_count_q <= err_count_q + 16'd1;
            if (uf_evt) underflow_q <= 1'b1;
            if (of_evt) overflow_q  <= 1'b1;
        end
    end

`ifdef ACT_CHECK_FIRST_ERR_EN
    logic             cap_valid_q;
    logic [WIDTH-1:0] first_in_q, first_exp_q, first_act_q;

    assign fifo_wr_data = {stimData, exp_val};

    // Latch the first mismatch of a run; later mismatches leave it intact.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            cap_valid_q <= 1'b0;
            first_in_q  <= '0;
            first_exp_q <= '0;
            first_act_q <= '0;
        end else if (start) begin
            cap_valid_q <= 1'b0;
            first_in_q  <= '0;
            first_exp_q <= '0;
            first_act_q <= '0;
        end else if (mismatch && !cap_valid_q) begin
            cap_valid_q <= 1'b1;
            first_in_q  <= fifo_rd_data[2*WIDTH-1:WIDTH];
            first_exp_q <= head_exp;
            first_act_q <= dutOut;
        end
    end

    assign firstErrIn  = first_in_q;
    assign firstErrExp = first_exp_q;
    assign firstErrAct = first_act_q;
`else
    assign fifo_wr_data = exp_val;
    assign firstErrIn   = '0;
    assign firstErrExp  = '0;
    assign firstErrAct  = '0;
`endif

    assign busy      = (state_q == ST_RUN);
    assign done      = (state_q == ST_DONE);
    assign pass      = done && (err_count_q == 16'd0) && !underflow_q && !overflow_q;
    assign errCount  = err_count_q;
    assign cmpCount  = cmp_count_q;
    assign underflow = underflow_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_act_response_checker.sv
// Directed bench for act_response_checker: three instances (relu, leaky,
// hardtanh). A 1-cycle-latency DUT model is built from a scoreboard queue:
// expected activations are pushed when stimulus is driven and popped to form
// dutOut when rdy is raised.
module tb_act_response_checker;

    logic              clk;
    logic              rst;
    logic              start_r, start_l, start_h;
    logic              stim_valid;
    logic signed [7:0] stim_data;
    logic signed [7:0] dut_out;
    logic              dut_rdy;

    logic        busy_r, done_r, pass_r, uf_r, of_r;
    logic [15:0] err_r, cmp_r;
    logic [7:0]  fin_r, fexp_r, fact_r;
    logic        busy_l, done_l, pass_l, uf_l, of_l;
    logic [15:0] err_l, cmp_l;
    logic [7:0]  fin_l, fexp_l, fact_l;
    logic        busy_h, done_h, pass_h, uf_h, of_h;
    logic [15:0] err_h, cmp_h;
    logic [7:0]  fin_h, fexp_h, fact_h;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    logic signed [7:0] exp_q [$];

    act_response_checker #(.WIDTH(8), .MODE(0), .NEGATIVE_SLOPE_SHIFT(5),
        .DECIMAL_POINT(4), .FIFO_DEPTH(4), .SWEEP_LEN(256)) u_relu (
        .iClk(clk), .iRst(rst), .start(start_r), .stimValid(stim_valid),
        .stimData(stim_data), .dutOut(dut_out), .dutRdy(dut_rdy),
        .busy(busy_r), .done(done_r), .pass(pass_r), .errCount(err_r),
        .cmpCount(cmp_r), .underflow(uf_r), .overflow(of_r),
        .firstErrIn(fin_r), .firstErrExp(fexp_r), .firstErrAct(fact_r));

    act_response_checker #(.WIDTH(8), .MODE(1), .NEGATIVE_SLOPE_SHIFT(5),
        .DECIMAL_POINT(4), .FIFO_DEPTH(4), .SWEEP_LEN(3)) u_leaky (
        .iClk(clk), .iRst(rst), .start(start_l), .stimValid(stim_valid),
        .stimData(stim_data), .dutOut(dut_out), .dutRdy(dut_rdy),
        .busy(busy_l), .done(done_l), .pass(pass_l), .errCount(err_l),
        .cmpCount(cmp_l), .underflow(uf_l), .overflow(of_l),
        .firstErrIn(fin_l), .firstErrExp(fexp_l), .firstErrAct(fact_l));

    act_response_checker #(.WIDTH(8), .MODE(2), .NEGATIVE_SLOPE_SHIFT(5),
        .DECIMAL_POINT(4), .FIFO_DEPTH(4), .SWEEP_LEN(3)) u_htanh (
        .iClk(clk), .iRst(rst), .start(start_h), .stimValid(stim_valid),
        .stimData(stim_data), .dutOut(dut_out), .dutRdy(dut_rdy),
        .busy(busy_h), .done(done_h), .pass(pass_h), .errCount(err_h),
        .cmpCount(cmp_h), .underflow(uf_h), .overflow(of_h),
        .firstErrIn(fin_h), .firstErrExp(fexp_h), .firstErrAct(fact_h));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock of traffic. A raised rdy pops the oldest expected value as
    // the DUT's answer (or 127 when corrupted); a valid stimulus pushes ev.
    task automatic cyc(input logic sv, input logic signed [7:0] sd,
                       input logic signed [7:0] ev, input logic rdy,
                       input logic corrupt);
        stim_valid = sv;
        stim_data  = sd;
        dut_rdy    = rdy;
        dut_out    = '0;
        if (rdy && exp_q.size() > 0) begin
            dut_out = exp_q.pop_front();
            if (corrupt) dut_out = 8'sd127;
        end
        if (sv) exp_q.push_back(ev);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int sel);
        stim_valid = 1'b0;
        dut_rdy    = 1'b0;
        exp_q.delete();
        start_r = (sel == 0);
        start_l = (sel == 1);
        start_h = (sel == 2);
        @(posedge clk);
        #1;
        start_r = 1'b0;
        start_l = 1'b0;
        start_h = 1'b0;
    endtask

    // Relu sweep from -128 upward: n pushes give n-1 comparisons so far.
    task automatic relu_sweep(input int n);
        logic signed [7:0] x;
        for (int i = 0; i < n; i++) begin
            x = 8'(i - 128);
            cyc(1'b1, x, (x < 0) ? 8'sd0 : x, (i > 0), 1'b0);
        end
    endtask

    initial begin
        rst = 1'b1;
        start_r = 1'b0; start_l = 1'b0; start_h = 1'b0;
        stim_valid = 1'b0; stim_data = '0; dut_out = '0; dut_rdy = 1'b0;

        // Reset values
        #2;
        check("rst_busy", busy_r, 0);
        check("rst_done", done_r, 0);
        check("rst_pass", pass_r, 0);
        check("rst_err", err_r, 0);
        check("rst_cmp", cmp_r, 0);
        check("rst_uf", uf_r, 0);
        check("rst_of", of_r, 0);
        check("rst_fin", fin_r, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("idle_busy", busy_r, 0);

        // Full relu sweep with a correct 1-cycle DUT
        pulse_start(0);
        check("run_busy", busy_r, 1);
        relu_sweep(256);
        check("sweep_cmp255", cmp_r, 255);
        check("sweep_not_done", done_r, 0);
        cyc(1'b0, 8'sd0, 8'sd0, 1'b1, 1'b0);
        check("sweep_cmp", cmp_r, 256);
        check("sweep_done", done_r, 1);
        check("sweep_pass", pass_r, 1);
        check("sweep_err", err_r, 0);
        check("sweep_busy", busy_r, 0);
        // rdy in DONE is ignored
        cyc(1'b0, 8'sd0, 8'sd0, 1'b1, 1'b0);
        check("done_hold_cmp", cmp_r, 256);
        check("done_hold_uf", uf_r, 0);
        check("done_hold", done_r, 1);

        // Leaky: -128 -> -4, -1 -> -1, 40 -> 40
        pulse_start(1);
        cyc(1'b1, -8'sd128, -8'sd4, 1'b0, 1'b0);
        cyc(1'b1, -8'sd1,   -8'sd1, 1'b1, 1'b0);
        cyc(1'b1, 8'sd40,   8'sd40, 1'b1, 1'b0);
        cyc(1'b0, 8'sd0,    8'sd0,  1'b1, 1'b0);
        check("leaky_err", err_l, 0);
        check("leaky_cmp", cmp_l, 3);
        check("leaky_done", done_l, 1);
        check("leaky_pass", pass_l, 1);
        check("leaky_flags", {uf_l, of_l, busy_l}, 0);
        check("leaky_cap", {fin_l, fexp_l, fact_l}, 0);

        // Hardtanh: 100 -> 16, -128 -> -16, 7 -> 7
        pulse_start(2);
        cyc(1'b1, 8'sd100,  8'sd16,  1'b0, 1'b0);
        cyc(1'b1, -8'sd128, -8'sd16, 1'b1, 1'b0);
        cyc(1'b1, 8'sd7,    8'sd7,   1'b1, 1'b0);
        cyc(1'b0, 8'sd0,    8'sd0,   1'b1, 1'b0);
        check("htanh_err", err_h, 0);
        check("htanh_cmp", cmp_h, 3);
        check("htanh_pass", pass_h, 1);
        check("htanh_flags", {uf_h, of_h, busy_h}, 0);
        check("htanh_cap", {fin_h, fexp_h, fact_h}, 0);

        // Relu mismatch: input 3 answered with 127, then input 5 answered with 127
        pulse_start(0);
        check("restart_cmp", cmp_r, 0);
        check("restart_done", done_r, 0);
        cyc(1'b1, 8'sd3, 8'sd3, 1'b0, 1'b0);
        cyc(1'b1, 8'sd5, 8'sd5, 1'b1, 1'b1);
        check("mm_err1", err_r, 1);
        check("mm_cmp1", cmp_r, 1);
        check("mm_pass", pass_r, 0);
        cyc(1'b0, 8'sd0, 8'sd0, 1'b1, 1'b1);
        check("mm_err2", err_r, 2);
`ifdef ACT_CHECK_FIRST_ERR_EN
        check("cap_in", fin_r, 3);
        check("cap_exp", fexp_r, 3);
        check("cap_act", fact_r, 127);
`else
        check("cap_in_off", fin_r, 0);
        check("cap_exp_off", fexp_r, 0);
        check("cap_act_off", fact_r, 0);
`endif

        // Underflow then overflow (depth 4)
        pulse_start(0);
        check("uf_clear_err", err_r, 0);
        check("uf_clear_cap", fin_r, 0);
        cyc(1'b0, 8'sd0, 8'sd0, 1'b1, 1'b0);
        check("uf_flag", uf_r, 1);
        check("uf_err", err_r, 1);
        check("uf_cmp", cmp_r, 1);
        for (int i = 0; i < 4; i++) cyc(1'b1, 8'(i), 8'(i), 1'b0, 1'b0);
        check("of_not_yet", of_r, 0);
        cyc(1'b1, 8'sd9, 8'sd9, 1'b0, 1'b0);
        check("of_flag", of_r, 1);
        check("of_err_unchanged", err_r, 1);

        // Asynchronous reset at comparison 100, then a clean rerun
        pulse_start(0);
        relu_sweep(101);
        check("mid_cmp100", cmp_r, 100);
        stim_valid = 1'b0;
        dut_rdy    = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("arst_busy", busy_r, 0);
        check("arst_cmp", cmp_r, 0);
        check("arst_err_flags", {err_r, uf_r, of_r, done_r, pass_r}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("arst_idle", busy_r, 0);
        pulse_start(0);
        relu_sweep(256);
        cyc(1'b0, 8'sd0, 8'sd0, 1'b1, 1'b0);
        check("rerun_cmp", cmp_r, 256);
        check("rerun_done", done_r, 1);
        check("rerun_pass", pass_r, 1);
        check("rerun_err", err_r, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
